zcmt_table_jump_unit: RTL and testbench

//  Executes Zcmt cm.jt/cm.jalt table jumps for XLEN=32/64. Decodes the 16-bit encoding, fetches the

---
 rtl/zcmt_pkg.sv | 26 ++
 rtl/zcmt_entry_buffer.sv | 70 +++++++
 rtl/zcmt_table_jump_unit.sv | 176 +++++++++++++++++
 tb/tb_zcmt_table_jump_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zcmt_pkg.sv
// Shared types and constants for the Zcmt table-jump unit.
// FSM state codes stay plain localparams so legacy code can keep comparing raw values.
package zcmt_pkg;

    typedef logic [2:0] zcmt_state_e;

    localparam zcmt_state_e ZCMT_IDLE = 3'd0;
    localparam zcmt_state_e ZCMT_REQ  = 3'd1;
    localparam zcmt_state_e ZCMT_WAIT = 3'd2;
    localparam zcmt_state_e ZCMT_DONE = 3'd3;
    localparam zcmt_state_e ZCMT_DROP = 3'd4;

    typedef enum logic {
        ZCMT_JT   = 1'b0,
        ZCMT_JALT = 1'b1
    } zcmt_kind_e;

    localparam int unsigned ZCMT_JALT_MIN_IDX = 32;
    localparam logic [2:0]  ZCMT_FUNCT3       = 3'b101;

    // Opcode-level check only; the jvt mode is qualified by the caller.
    function automatic logic zcmt_is_encoding(input logic [15:0] instr);
        return (instr[1:0] == 2'b10) && (instr[15:13] == ZCMT_FUNCT3) && (instr[12:10] == 3'b000);
    endfunction

endpackage

// File: rtl/zcmt_entry_buffer.sv
// Fully-associative buffer of recently loaded jump-table entries, tagged by table index.
// Round-robin replacement; a flush invalidates every slot.
module zcmt_entry_buffer #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NR_ENTRIES = 4,
    parameter int unsigned IDX_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             hit_o,
    output logic [XLEN-1:0]  hit_data_o,
    input  logic             fill_i,
    input  logic [IDX_W-1:0] fill_idx_i,
    input  logic [XLEN-1:0]  fill_data_i
);

    localparam int unsigned PTR_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    logic [NR_ENTRIES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]      tag_q  [NR_ENTRIES];
    logic [IDX_W-1:0]      tag_d  [NR_ENTRIES];
    logic [XLEN-1:0]       data_q [NR_ENTRIES];
    logic [XLEN-1:0]       data_d [NR_ENTRIES];
    logic [PTR_W-1:0]      rr_q, rr_d;

    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_idx_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        rr_d    = rr_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (fill_i) begin
            valid_d[rr_q] = 1'b1;
            tag_d[rr_q]   = fill_idx_i;
            data_d[rr_q]  = fill_data_i;
            rr_d          = (rr_q == PTR_W'(NR_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            rr_q    <= '0;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/zcmt_table_jump_unit.sv
// Zcmt cm.jt / cm.jalt execution: decode, jump-table load through the data cache port,
// and a small entry buffer so repeated table jumps complete in one cycle.
module zcmt_table_jump_unit #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned NR_ENTRIES = 4,
    parameter int unsigned IDX_W      = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [15:0]     instr_i,
    input  logic [XLEN-1:0] jvt_i,
    output logic            req_o,
    input  logic            gnt_i,
    output logic [XLEN-1:0] addr_o,
    output logic [1:0]      size_o,
    input  logic            rvalid_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic            err_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] target_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o,
    output logic            fault_o,
    output logic [XLEN-1:0] tval_o,
    output logic            stall_o
);

    import zcmt_pkg::*;

    localparam int unsigned ENTRY_SHIFT = $clog2(XLEN / 8);
    localparam logic [1:0]  ENTRY_SIZE  = (XLEN == 64) ? 2'b11 : 2'b10;

    zcmt_state_e      state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    zcmt_kind_e       kind_q, kind_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             illegal_q, illegal_d;
    logic             fault_q, fault_d;
    logic [XLEN-1:0]  tval_q, tval_d;

    logic [IDX_W-1:0] dec_idx;
    logic             dec_legal;
    zcmt_kind_e       dec_kind;
    logic [XLEN-1:0]  dec_addr;
    logic             buf_hit;
    logic             hit;
    logic [XLEN-1:0]  hit_data;
    logic             fill;

    assign dec_idx   = instr_i[2 +: IDX_W];
    assign dec_legal = zcmt_is_encoding(instr_i) && (jvt_i[5:0] == 6'b0);
    assign dec_kind  = (dec_idx >= IDX_W'(ZCMT_JALT_MIN_IDX)) ? ZCMT_JALT : ZCMT_JT;
    assign dec_addr  = {jvt_i[XLEN-1:6], 6'b0} + (XLEN'(dec_idx) << ENTRY_SHIFT);
    // An illegal encoding must never complete as a buffered hit.
    assign hit       = buf_hit && dec_legal;

    zcmt_entry_buffer #(
        .XLEN       (XLEN),
        .NR_ENTRIES (NR_ENTRIES),
        .IDX_W      (IDX_W)
    ) u_entry_buffer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .lookup_idx_i (dec_idx),
        .hit_o        (buf_hit),
        .hit_data_o   (hit_data),
        .fill_i       (fill),
        .fill_idx_i   (idx_q),
        .fill_data_i  (target_d)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        kind_d    = kind_q;
        target_d  = target_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        tval_d    = tval_q;
        fill      = 1'b0;
        case (state_q)
            ZCMT_IDLE: begin
                if (!flush_i && valid_i) begin
                    kind_d    = dec_kind;
                    illegal_d = !dec_legal;
                    fault_d   = 1'b0;
                    tval_d    = '0;
                    if (!dec_legal) begin
                        target_d = '0;
                        state_d  = ZCMT_DONE;
                    end else if (hit) begin
                        target_d = hit_data;
                        state_d  = ZCMT_DONE;
                    end else begin
                        addr_d  = dec_addr;
                        idx_d   = dec_idx;
                        state_d = ZCMT_REQ;
                    end
                end
            end
            ZCMT_REQ: begin
                if (flush_i) begin
                    state_d = gnt_i ? ZCMT_DROP : ZCMT_IDLE;
                end else if (gnt_i) begin
                    state_d = ZCMT_WAIT;
                end
            end
            ZCMT_WAIT: begin
                if (rvalid_i) begin
                    if (flush_i) begin
                        state_d = ZCMT_IDLE;
                    end else begin
                        state_d  = ZCMT_DONE;
                        fault_d  = err_i;
                        target_d = err_i ? '0 : (rdata_i & ~XLEN'(1));
                        tval_d   = err_i ? addr_q : '0;
                        fill     = !err_i;
                    end
                end else if (flush_i) begin
                    state_d = ZCMT_DROP;
                end
            end
            ZCMT_DONE: begin
                if (flush_i || ready_i) begin
                    state_d = ZCMT_IDLE;
                end
            end
            ZCMT_DROP: begin
                if (rvalid_i) begin
                    state_d = ZCMT_IDLE;
                end
            end
            default: state_d = ZCMT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ZCMT_IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            kind_q    <= ZCMT_JT;
            target_q  <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            tval_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            kind_q    <= kind_d;
            target_q  <= target_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            tval_q    <= tval_d;
        end
    end

    assign req_o     = (state_q == ZCMT_REQ);
    assign valid_o   = (state_q == ZCMT_DONE);
    assign addr_o    = addr_q;
    assign size_o    = req_o ? ENTRY_SIZE : 2'b00;
    assign target_o  = target_q;
    assign rd_o      = (kind_q == ZCMT_JALT) ? 5'd1 : 5'd0;
    assign illegal_o = illegal_q;
    assign fault_o   = fault_q;
    assign tval_o    = tval_q;
    assign stall_o   = (state_q != ZCMT_IDLE) || (valid_i && !hit);

endmodule

// File: tb/tb_zcmt_table_jump_unit.sv
// Drives an XLEN=32 and an XLEN=64 instance in lockstep with directed table-jump vectors
// and checks both against a transaction-level model of decode, addressing and the FIFO-evicting buffer.
module tb_zcmt_table_jump_unit;

    localparam int NR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, valid = 1'b0, gnt = 1'b0, rvalid = 1'b0, err = 1'b0, ready = 1'b0;
    logic [15:0] instr = '0;
    logic [63:0] jvt = '0, rdata = '0;

    logic        q32, v32, il32, f32, s32;
    logic [31:0] a32, t32, tv32;
    logic [1:0]  sz32;
    logic [4:0]  rd32;
    logic        q64, v64, il64, f64, s64;
    logic [63:0] a64, t64, tv64;
    logic [1:0]  sz64;
    logic [4:0]  rd64;

    always #5 clk = ~clk;

    zcmt_table_jump_unit #(.XLEN(32), .NR_ENTRIES(NR), .IDX_W(8)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .instr_i(instr),
        .jvt_i(jvt[31:0]), .req_o(q32), .gnt_i(gnt), .addr_o(a32), .size_o(sz32),
        .rvalid_i(rvalid), .rdata_i(rdata[31:0]), .err_i(err), .valid_o(v32), .ready_i(ready),
        .target_o(t32), .rd_o(rd32), .illegal_o(il32), .fault_o(f32), .tval_o(tv32), .stall_o(s32)
    );

    zcmt_table_jump_unit #(.XLEN(64), .NR_ENTRIES(NR), .IDX_W(8)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .instr_i(instr),
        .jvt_i(jvt), .req_o(q64), .gnt_i(gnt), .addr_o(a64), .size_o(sz64),
        .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err), .valid_o(v64), .ready_i(ready),
        .target_o(t64), .rd_o(rd64), .illegal_o(il64), .fault_o(f64), .tval_o(tv64), .stall_o(s64)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: buffer contents as an ordered list, oldest first.
    logic [7:0]  q_idx[$];
    logic [63:0] q_dat[$];

    logic [7:0]  exp_idx;
    logic        exp_legal, exp_hit, exp_rd, exp_fault;
    logic [63:0] exp_a32, exp_a64, exp_t32, exp_t64;
    logic        req_allowed = 1'b0, out_allowed = 1'b0;

    logic        cap_req, cap_ill, cap_fault;
    logic [63:0] cap_a32, cap_a64, cap_t32, cap_t64, cap_tv32, cap_tv64;
    logic [1:0]  cap_s32, cap_s64;
    logic [4:0]  cap_rd;

    task automatic predict(input logic [15:0] ins, input logic [63:0] j);
        logic [31:0] base32;
        exp_idx   = ins[9:2];
        exp_legal = (ins[1:0] == 2'b10) && (ins[15:13] == 3'b101) && (ins[12:10] == 3'b000)
                    && (j[5:0] == 6'd0);
        exp_rd    = (exp_idx >= 8'd32);
        exp_a64   = (j & ~64'h3f) + 64'(exp_idx) * 64'd8;
        base32    = (j[31:0] & ~32'h3f) + 32'(exp_idx) * 32'd4;
        exp_a32   = {32'd0, base32};
        exp_fault = 1'b0;
        exp_hit   = 1'b0;
        for (int i = 0; i < q_idx.size(); i++) begin
            if (q_idx[i] == exp_idx) begin
                exp_hit = 1'b1;
                exp_t64 = q_dat[i];
            end
        end
        exp_hit = exp_hit && exp_legal;
        exp_t32 = {32'd0, exp_t64[31:0]};
    endtask

    task automatic model_fill(input logic [7:0] idx, input logic [63:0] data);
        if (q_idx.size() == NR) begin
            void'(q_idx.pop_front());
            void'(q_dat.pop_front());
        end
        q_idx.push_back(idx);
        q_dat.push_back(data & ~64'h1);
    endtask

    task automatic model_flush();
        q_idx.delete();
        q_dat.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && (v32 || v64)) begin
            chk("valid_allowed", out_allowed, 1'b1);
            chk("valid_lockstep", v32, v64);
            chk("illegal32", il32, !exp_legal);
            chk("illegal64", il64, !exp_legal);
            chk("fault32", f32, exp_fault);
            chk("fault64", f64, exp_fault);
            if (exp_legal && !exp_fault) begin
                chk("target32", t32, exp_t32);
                chk("target64", t64, exp_t64);
                chk("rd32", rd32, exp_rd);
                chk("rd64", rd64, exp_rd);
            end
            if (exp_fault) begin
                chk("tval32", tv32, exp_a32);
                chk("tval64", tv64, exp_a64);
            end
        end
        if (rst_n && (q32 || q64)) begin
            chk("req_allowed", req_allowed, 1'b1);
            chk("req_lockstep", q32, q64);
            chk("addr32", a32, exp_a32);
            chk("addr64", a64, exp_a64);
            chk("size32", sz32, 2'b10);
            chk("size64", sz64, 2'b11);
        end
    end

    task automatic op(input logic [15:0] ins, input logic [63:0] j, input logic [63:0] rd,
                      input logic e, input int gd, input int rvd, input int rdyd);
        predict(ins, j);
        @(posedge clk); #1;
        valid = 1'b1; instr = ins; jvt = j;
        req_allowed = exp_legal && !exp_hit;
        out_allowed = !exp_legal || exp_hit;
        @(negedge clk);
        chk("stall32_decode", s32, !(exp_legal && exp_hit));
        chk("stall64_decode", s64, !(exp_legal && exp_hit));
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        cap_req = q32;
        if (!req_allowed) begin
            chk("latency_valid32", v32, 1'b1);
            chk("latency_valid64", v64, 1'b1);
        end else begin
            chk("latency_req32", q32, 1'b1);
            chk("latency_req64", q64, 1'b1);
            cap_a32 = {32'd0, a32}; cap_a64 = a64; cap_s32 = sz32; cap_s64 = sz64;
            repeat (gd) @(posedge clk);
            @(posedge clk); #1 gnt = 1'b1;
            @(posedge clk); #1 gnt = 1'b0; req_allowed = 1'b0;
            repeat (rvd) @(posedge clk);
            #1;
            rvalid = 1'b1; rdata = rd; err = e;
            exp_fault = e;
            if (!e) begin
                exp_t64 = rd & ~64'h1;
                exp_t32 = {32'd0, exp_t64[31:0]};
                model_fill(exp_idx, rd);
            end
            out_allowed = 1'b1;
            @(posedge clk); #1 rvalid = 1'b0; err = 1'b0;
            @(negedge clk);
            chk("latency_rvalid32", v32, 1'b1);
            chk("latency_rvalid64", v64, 1'b1);
        end
        cap_t32 = {32'd0, t32}; cap_t64 = t64; cap_rd = rd64;
        cap_ill = il32; cap_fault = f64; cap_tv32 = {32'd0, tv32}; cap_tv64 = tv64;
        repeat (rdyd) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0; out_allowed = 1'b0;
        @(negedge clk);
        chk("release32", v32, 1'b0);
        chk("release64", v64, 1'b0);
    endtask

    task automatic op_flush_wait(input logic [15:0] ins, input logic [63:0] j);
        predict(ins, j);
        @(posedge clk); #1;
        valid = 1'b1; instr = ins; jvt = j;
        req_allowed = 1'b1; out_allowed = 1'b0;
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1 gnt = 1'b1;
        @(posedge clk); #1 gnt = 1'b0; req_allowed = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model_flush();
        @(negedge clk);
        chk("drop_stall32", s32, 1'b1);
        chk("drop_stall64", s64, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rvalid = 1'b1; rdata = 64'hdead_beef_cafe_f00d;
        @(posedge clk); #1 rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_idle_stall32", s32, 1'b0);
        chk("drop_idle_stall64", s64, 1'b0);
    endtask

    task automatic idle_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        model_flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req", {q32, q64}, 2'b00);
        chk("reset_valid", {v32, v64}, 2'b00);
        chk("reset_addr64", a64, 64'd0);
        chk("reset_size", {sz32, sz64}, 4'd0);
        chk("reset_target64", t64, 64'd0);
        chk("reset_rd", {rd32, rd64}, 10'd0);
        chk("reset_flags", {il32, il64, f32, f64}, 4'd0);
        chk("reset_tval", {tv32, tv64[31:0]}, 64'd0);
        chk("reset_stall", {s32, s64}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;

        // cm.jt idx 5 through jvt 0x8000_0000
        op(16'hA016, 64'h8000_0000, 64'h1235, 1'b0, 1, 1, 0);
        chk("t1_addr32", cap_a32, 64'h8000_0014);
        chk("t1_size32", cap_s32, 2'b10);
        chk("t1_addr64", cap_a64, 64'h8000_0028);
        chk("t1_target32", cap_t32, 64'h1234);
        chk("t1_rd", cap_rd, 5'd0);

        // cm.jalt idx 40, then a repeat served from the buffer
        op(16'hA0A2, 64'h1000, 64'h1122_3344_5566_7789, 1'b0, 0, 0, 0);
        chk("t2_addr64", cap_a64, 64'h1140);
        chk("t2_size64", cap_s64, 2'b11);
        chk("t2_rd", cap_rd, 5'd1);
        chk("t2_target64", cap_t64, 64'h1122_3344_5566_7788);
        op(16'hA0A2, 64'h1000, 64'h0, 1'b0, 0, 0, 0);
        chk("t2_hit_noreq", cap_req, 1'b0);
        chk("t2_hit_target64", cap_t64, 64'h1122_3344_5566_7788);

        // illegal: jvt mode, funct bits, opcode bits
        op(16'hA0A2, 64'h1001, 64'h0, 1'b0, 0, 0, 0);
        chk("t3_mode_illegal", cap_ill, 1'b1);
        op(16'hA4A2, 64'h1000, 64'h0, 1'b0, 0, 0, 1);
        chk("t3_funct_illegal", cap_ill, 1'b1);
        op(16'hA0A1, 64'h1000, 64'h0, 1'b0, 0, 0, 0);
        op(16'hA01E, 64'h1001, 64'h0, 1'b0, 0, 0, 0);
        op(16'hA01E, 64'h1000, 64'h0000_0777_0000_0071, 1'b0, 0, 2, 0);
        chk("t3_no_fill_miss", cap_req, 1'b1);

        // access fault, then the same index must load again
        op(16'hA026, 64'h2000, 64'h5555, 1'b1, 0, 2, 1);
        chk("t4_fault", cap_fault, 1'b1);
        chk("t4_tval64", cap_tv64, 64'h2048);
        chk("t4_tval32", cap_tv32, 64'h2024);
        op(16'hA026, 64'h2000, 64'h6667, 1'b0, 2, 0, 0);
        chk("t4_refetch", cap_req, 1'b1);

        // flush while waiting on the load: response discarded, buffer emptied
        op_flush_wait(16'hA0CA, 64'h1000);
        op(16'hA0A2, 64'h1000, 64'h0000_0000_0000_4441, 1'b0, 0, 0, 0);
        chk("t5_buffer_empty", cap_req, 1'b1);

        // NR+1 distinct indexes evict the oldest
        idle_flush();
        for (int i = 10; i <= 14; i++) begin
            op(16'hA002 | 16'(i << 2), 64'h3000, 64'h0000_00AB_0000_0001 | 64'(i << 8), 1'b0, 0, 1, 0);
        end
        for (int i = 11; i <= 14; i++) begin
            op(16'hA002 | 16'(i << 2), 64'h3000, 64'h0, 1'b0, 0, 0, (i == 12) ? 5 : 0);
        end
        chk("t6_idx14_hit", cap_req, 1'b0);
        chk("t6_idx14_target64", cap_t64, 64'h0000_00AB_0000_0E00);
        op(16'hA02A, 64'h3000, 64'h0000_0000_0000_0A01, 1'b0, 0, 0, 0);
        chk("t6_idx10_evicted", cap_req, 1'b1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
